// File: rtl/hub75_fb_ctrl.sv
// hub75_fb_ctrl: double-buffer frame-buffer controller placed between a pixel
// writer and the read port of a HUB75 panel driver.
//
// The writer fills the back bank while the driver scans the front bank. Banks
// swap only at a driver frame boundary, which keeps a frame from tearing.
//
// Ports:
//   CLK, RESET_N     system clock, asynchronous active-low reset
//   WR_VALID/READY   pixel handshake; a transfer is WR_VALID & WR_READY
//   WR_ADDR/WR_DATA  pixel address within a bank and pixel data
//   WR_FRAME_END     writer finished the back-bank image and requests a swap
//   DRV_FRAME_SYNC   driver returned to row 0 (frame start)
//   RAM_WE/WADDR/WDATA  registered RAM write port, WADDR = {back bank, addr}
//   RD_BANK          front bank, MSB of the driver read address
//   SWAP_PENDING     waiting for a frame sync (or swapping)
//   FRAME_CNT        completed swaps, wraps at 16 bits
//   SWAP_ERR         sticky flag set by a forced swap
//
// Optional build macro HUB75_FB_SWAP_TIMEOUT_EN: when defined, a pending swap
// is forced after SWAP_TIMEOUT cycles without a frame sync and SWAP_ERR is set.
// When undefined, the controller waits indefinitely and SWAP_ERR is tied 0.
//
// state    | meaning
// ST_WRITE | writer may fill the back bank
// ST_PEND  | image complete, waiting for the driver frame sync
// ST_SWAP  | one cycle; the front/back banks exchange at its exit

module hub75_fb_ctrl #(
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter int          MEM_DATA_WIDTH = 9,
  parameter int unsigned SWAP_TIMEOUT   = 1048575
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      WR_VALID,
  output logic                      WR_READY,
  input  logic [MEM_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [MEM_DATA_WIDTH-1:0] WR_DATA,
  input  logic                      WR_FRAME_END,
  input  logic                      DRV_FRAME_SYNC,
  output logic                      RAM_WE,
  output logic [MEM_ADDR_WIDTH:0]   RAM_WADDR,
  output logic [MEM_DATA_WIDTH-1:0] RAM_WDATA,
  output logic                      RD_BANK,
  output logic                      SWAP_PENDING,
  output logic [15:0]               FRAME_CNT,
  output logic                      SWAP_ERR
);

  typedef enum logic [1:0] {
    ST_WRITE = 2'd0,
    ST_PEND  = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic                      ready_en_q;
  logic                      ram_we_q;
  logic [MEM_ADDR_WIDTH:0]   ram_waddr_q;
  logic [MEM_DATA_WIDTH-1:0] ram_wdata_q;
  logic                      swap_pending;
  logic                      accept;

`ifdef HUB75_FB_SWAP_TIMEOUT_EN
  localparam int TMR_W = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SWAP_TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
`else
  // SWAP_TIMEOUT only matters with the timeout build; keep it referenced.
  logic unused_cfg;
  assign unused_cfg = (SWAP_TIMEOUT == 0);
`endif

  // WR_READY stays low until the first clock after reset release.
  assign WR_READY = ready_en_q & (state_q == ST_WRITE);
  assign accept   = WR_VALID & WR_READY;

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    frame_cnt_d  = frame_cnt_q;
    swap_pending = 1'b0;
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
    tmr_d        = tmr_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_WRITE: begin
        // A sync coinciding with the frame end is ignored here, so the swap
        // waits for the following sync.
        if (WR_FRAME_END) begin
          state_d = ST_PEND;
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
`endif
        end
      end
      ST_PEND: begin
        swap_pending = 1'b1;
        if (DRV_FRAME_SYNC) begin
          state_d = ST_SWAP;
        end
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
        else if (tmr_q == '0) begin
          state_d = ST_SWAP;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      ST_SWAP: begin
        swap_pending = 1'b1;
        state_d      = ST_WRITE;
        rd_bank_d    = ~rd_bank_q;
        frame_cnt_d  = frame_cnt_q + 16'd1;
      end
      default: begin
        state_d = ST_WRITE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_WRITE;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      ready_en_q  <= 1'b0;
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
      tmr_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      frame_cnt_q <= frame_cnt_d;
      ready_en_q  <= 1'b1;
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
      tmr_q       <= tmr_d;
      err_q       <= err_d;
`endif
    end
  end

  // The write address is captured with the pre-swap back bank, so a write
  // accepted in ST_WRITE can never land in the front bank.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_we_q <= accept;
      if (accept) begin
        ram_waddr_q <= {~rd_bank_q, WR_ADDR};
        ram_wdata_q <= WR_DATA;
      end
    end
  end

  assign RAM_WE       = ram_we_q;
  assign RAM_WADDR    = ram_waddr_q;
  assign RAM_WDATA    = ram_wdata_q;
  assign RD_BANK      = rd_bank_q;
  assign SWAP_PENDING = swap_pending;
  assign FRAME_CNT    = frame_cnt_q;
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
  assign SWAP_ERR     = err_q;
`else
  assign SWAP_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_fb_ctrl.sv
// Bench for hub75_fb_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all continuously compared against a behavioural model.
module tb_hub75_fb_ctrl;

  localparam int          AW = 10;
  localparam int          DW = 9;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_frame_end = 1'b0;
  logic          drv_sync = 1'b0;

  logic          wr_ready;
  logic          ram_we;
  logic [AW:0]   ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          rd_bank;
  logic          swap_pending;
  logic [15:0]   frame_cnt;
  logic          swap_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hub75_fb_ctrl #(
    .MEM_ADDR_WIDTH (AW),
    .MEM_DATA_WIDTH (DW),
    .SWAP_TIMEOUT   (TO)
  ) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .WR_VALID       (wr_valid),
    .WR_READY       (wr_ready),
    .WR_ADDR        (wr_addr),
    .WR_DATA        (wr_data),
    .WR_FRAME_END   (wr_frame_end),
    .DRV_FRAME_SYNC (drv_sync),
    .RAM_WE         (ram_we),
    .RAM_WADDR      (ram_waddr),
    .RAM_WDATA      (ram_wdata),
    .RD_BANK        (rd_bank),
    .SWAP_PENDING   (swap_pending),
    .FRAME_CNT      (frame_cnt),
    .SWAP_ERR       (swap_err)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: "awaiting sync" and "swapping now" flags plus the
  // front bank index, frame count and the last write issued.
  bit          m_ready_en, m_wait, m_swap, m_front, m_we, m_err;
  bit [AW:0]   m_waddr;
  bit [DW-1:0] m_wdata;
  bit [15:0]   m_cnt;
  int          m_pcyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready_en <= 1'b0; m_wait <= 1'b0; m_swap <= 1'b0; m_front <= 1'b0;
      m_we <= 1'b0; m_err <= 1'b0; m_waddr <= '0; m_wdata <= '0;
      m_cnt <= 16'd0; m_pcyc <= 0;
    end else begin
      m_ready_en <= 1'b1;
      if (wr_valid && m_ready_en && !m_wait && !m_swap) begin
        m_we    <= 1'b1;
        m_waddr <= {~m_front, wr_addr};
        m_wdata <= wr_data;
      end else begin
        m_we <= 1'b0;
      end
      if (m_swap) begin
        m_swap  <= 1'b0;
        m_front <= ~m_front;
        m_cnt   <= m_cnt + 16'd1;
      end else if (m_wait) begin
        if (drv_sync) begin
          m_wait <= 1'b0;
          m_swap <= 1'b1;
        end
`ifdef HUB75_FB_SWAP_TIMEOUT_EN
        else if (m_pcyc == int'(TO) - 1) begin
          m_wait <= 1'b0;
          m_swap <= 1'b1;
          m_err  <= 1'b1;
        end else begin
          m_pcyc <= m_pcyc + 1;
        end
`endif
      end else if (wr_frame_end) begin
        m_wait <= 1'b1;
        m_pcyc <= 0;
      end
    end
  end

  always @(negedge clk) begin
    cmp("wr_ready",     32'(wr_ready),     32'(m_ready_en && !m_wait && !m_swap));
    cmp("ram_we",       32'(ram_we),       32'(m_we));
    cmp("ram_waddr",    32'(ram_waddr),    32'(m_waddr));
    cmp("ram_wdata",    32'(ram_wdata),    32'(m_wdata));
    cmp("rd_bank",      32'(rd_bank),      32'(m_front));
    cmp("swap_pending", 32'(swap_pending), 32'(m_wait || m_swap));
    cmp("frame_cnt",    32'(frame_cnt),    32'(m_cnt));
    cmp("swap_err",     32'(swap_err),     32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    cmp("lit_rst_ready", 32'(wr_ready), 32'd0);
    cmp("lit_rst_waddr", 32'(ram_waddr), 32'd0);

    rst_n = 1'b1;
    tick();
    cmp("lit_rel_bank",  32'(rd_bank),   32'd0);
    cmp("lit_rel_ready", 32'(wr_ready),  32'd1);
    cmp("lit_rel_cnt",   32'(frame_cnt), 32'd0);

    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 9'h1A3;
    tick();
    wr_valid = 1'b0;
    cmp("lit_wr_we",    32'(ram_we),    32'd1);
    cmp("lit_wr_waddr", 32'(ram_waddr), 32'h405);
    cmp("lit_wr_wdata", 32'(ram_wdata), 32'h1A3);
    tick();
    cmp("lit_wr_idle_we",   32'(ram_we),    32'd0);
    cmp("lit_wr_hold_addr", 32'(ram_waddr), 32'h405);

    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    cmp("lit_pend_ready", 32'(wr_ready),     32'd0);
    cmp("lit_pend_flag",  32'(swap_pending), 32'd1);
    repeat (99) tick();
    cmp("lit_pend99_flag", 32'(swap_pending), 32'd1);
    drv_sync = 1'b1;
    tick();
    drv_sync = 1'b0;
    cmp("lit_sync1_bank", 32'(rd_bank), 32'd0);
    tick();
    cmp("lit_sync2_bank", 32'(rd_bank),   32'd1);
    cmp("lit_sync2_cnt",  32'(frame_cnt), 32'd1);
    cmp("lit_sync2_pend", 32'(swap_pending), 32'd0);
    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 9'h0AA;
    tick();
    wr_valid = 1'b0;
    cmp("lit_bank0_waddr", 32'(ram_waddr), 32'h005);

    // last pixel together with frame end, next pixel held through the swap
    wr_valid = 1'b1; wr_addr = 10'd7; wr_data = 9'h111; wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0; wr_addr = 10'd8; wr_data = 9'h0BB;
    cmp("lit_last_we",    32'(ram_we),    32'd1);
    cmp("lit_last_waddr", 32'(ram_waddr), 32'h007);
    tick();
    cmp("lit_held_we", 32'(ram_we), 32'd0);
    drv_sync = 1'b1;
    tick();
    drv_sync = 1'b0;
    tick();
    cmp("lit_sw2_bank", 32'(rd_bank),   32'd0);
    cmp("lit_sw2_cnt",  32'(frame_cnt), 32'd2);
    tick();
    wr_valid = 1'b0;
    cmp("lit_released_we",    32'(ram_we),    32'd1);
    cmp("lit_released_waddr", 32'(ram_waddr), 32'h408);

    // sync without a frame end
    drv_sync = 1'b1;
    tick();
    drv_sync = 1'b0;
    tick();
    cmp("lit_nosw_bank", 32'(rd_bank),   32'd0);
    cmp("lit_nosw_cnt",  32'(frame_cnt), 32'd2);

    // frame end coincident with sync: pending only
    wr_frame_end = 1'b1; drv_sync = 1'b1;
    tick();
    wr_frame_end = 1'b0; drv_sync = 1'b0;
    tick();
    cmp("lit_coin_pend", 32'(swap_pending), 32'd1);
    cmp("lit_coin_bank", 32'(rd_bank),      32'd0);
    drv_sync = 1'b1;
    tick();
    drv_sync = 1'b0;
    tick();
    cmp("lit_coin_bank2", 32'(rd_bank),   32'd1);
    cmp("lit_coin_cnt2",  32'(frame_cnt), 32'd3);

    // reset while pending
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp("lit_midrst_pend",  32'(swap_pending), 32'd0);
    cmp("lit_midrst_bank",  32'(rd_bank),      32'd0);
    cmp("lit_midrst_cnt",   32'(frame_cnt),    32'd0);
    cmp("lit_midrst_ready", 32'(wr_ready),     32'd0);
    cmp("lit_midrst_waddr", 32'(ram_waddr),    32'd0);
    tick();
    rst_n = 1'b1;
    drv_sync = 1'b1;
    tick();
    drv_sync = 1'b0;
    tick();
    cmp("lit_postrst_bank", 32'(rd_bank),   32'd0);
    cmp("lit_postrst_cnt",  32'(frame_cnt), 32'd0);

`ifdef HUB75_FB_SWAP_TIMEOUT_EN
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    repeat (15) tick();
    cmp("lit_to15_pend", 32'(swap_pending), 32'd1);
    cmp("lit_to15_err",  32'(swap_err),     32'd0);
    tick();
    tick();
    cmp("lit_to_bank", 32'(rd_bank),  32'd1);
    cmp("lit_to_err",  32'(swap_err), 32'd1);
    repeat (5) tick();
    cmp("lit_to_sticky", 32'(swap_err), 32'd1);
`else
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    repeat (1000) tick();
    cmp("lit_wait_pend", 32'(swap_pending), 32'd1);
    cmp("lit_wait_bank", 32'(rd_bank),      32'd0);
    cmp("lit_wait_err",  32'(swap_err),     32'd0);
    drv_sync = 1'b1;
    tick();
    drv_sync = 1'b0;
    tick();
    cmp("lit_wait_swap", 32'(rd_bank), 32'd1);
`endif

    // randomized traffic
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_addr      = AW'($urandom);
      wr_data      = DW'($urandom);
      wr_frame_end = ($urandom_range(0, 39) == 0);
      drv_sync     = ($urandom_range(0, 24) == 0);
      tick();
    end
    wr_valid = 1'b0; wr_frame_end = 1'b0; drv_sync = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_fb_ctrl.md
Name: hub75_fb_ctrl

Overview:
Double-buffer frame-buffer controller that sits between an image source (pixel writer) and the HUB75 panel driver's memory read port.
- Owns two RAM banks. The writer fills the back bank while the driver scans the front bank.
- Bank swap happens only at a driver frame boundary, so no tearing occurs.
- Produces the RAM write port and the bank-select bit that is concatenated onto the driver's read address.

Parameters:
MEM_ADDR_WIDTH, 10, pixel address width within one bank (matches driver MEM_ADDR).
MEM_DATA_WIDTH, 9, pixel word width (3 x PIXEL_DEPTH, R/G/B).
SWAP_TIMEOUT, 1048575, cycles to wait for frame sync before a forced swap (used only with the optional feature).

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
WR_VALID  in  1  writer presents a pixel
WR_READY  out  1  controller accepts the pixel (transfer = WR_VALID & WR_READY)
WR_ADDR  in  MEM_ADDR_WIDTH  pixel address within the bank
WR_DATA  in  MEM_DATA_WIDTH  pixel data
WR_FRAME_END  in  1  one-cycle pulse: writer finished the back-bank image, requests swap
DRV_FRAME_SYNC  in  1  one-cycle pulse from the driver when it returns to row 0 (frame start)
RAM_WE  out  1  RAM write enable
RAM_WADDR  out  MEM_ADDR_WIDTH+1  {back bank, WR_ADDR}
RAM_WDATA  out  MEM_DATA_WIDTH  registered WR_DATA
RD_BANK  out  1  front bank; MSB of the driver read address
SWAP_PENDING  out  1  high while waiting for frame sync
FRAME_CNT  out  16  count of completed swaps, wraps at 65535 -> 0
SWAP_ERR  out  1  sticky flag: forced swap occurred (optional feature only; else tied 0)

Behaviour:
Reset values (RESET_N low, asynchronous):
- State = ST_WRITE; RD_BANK = 0; back bank = 1.
- RAM_WE = 0; RAM_WADDR = 0; RAM_WDATA = 0.
- WR_READY = 0 during reset, 1 from the first clock after release.
- FRAME_CNT = 0; SWAP_PENDING = 0; SWAP_ERR = 0.
- Reset mid-operation abandons any pending swap and any in-flight write. Bank contents are left untouched.

Write path:
- One-cycle registered latency.
- On an accepted transfer at edge N: RAM_WE = 1, RAM_WADDR = {~RD_BANK, WR_ADDR}, RAM_WDATA = WR_DATA during cycle N+1.
- Otherwise RAM_WE = 0.
- RAM_WADDR and RAM_WDATA hold their last value when RAM_WE = 0.

States:
- ST_WRITE: WR_READY = 1.
  - WR_FRAME_END -> ST_PEND.
  - A transfer in the same cycle as WR_FRAME_END is accepted as the last pixel of the frame.
  - DRV_FRAME_SYNC is ignored in this state.
- ST_PEND: WR_READY = 0; SWAP_PENDING = 1.
  - DRV_FRAME_SYNC -> ST_SWAP.
  - Further WR_FRAME_END pulses are ignored.
  - If WR_FRAME_END and DRV_FRAME_SYNC coincide while in ST_WRITE: enter ST_PEND only. The swap waits for the next sync.
- ST_SWAP: one cycle.
  - RD_BANK toggles at exit.
  - FRAME_CNT increments.
  - WR_READY = 0; SWAP_PENDING = 1.
  - Next state ST_WRITE.
- RD_BANK timing: changes exactly 2 edges after the DRV_FRAME_SYNC pulse (sync at edge N -> ST_SWAP; RD_BANK new at edge N+1). The driver's 1-cycle address register absorbs this before the first row read.
- Back bank is always ~RD_BANK. A write issued in ST_WRITE never targets the front bank, because the registered RAM_WADDR is captured before any toggle.
- Illegal state encodings -> ST_WRITE.

Optional Feature:
HUB75_FB_SWAP_TIMEOUT_EN
- Defined:
  - A cycle counter runs in ST_PEND and clears on entry.
  - When it reaches SWAP_TIMEOUT-1 without DRV_FRAME_SYNC, go to ST_SWAP and set SWAP_ERR (sticky until reset).
  - A sync arriving in the same cycle as the timeout counts as a normal swap; SWAP_ERR is not set.
- Undefined: no counter; ST_PEND waits indefinitely; SWAP_ERR tied 0.

Test Plan:
- Reset release -> RD_BANK=0, WR_READY=1, FRAME_CNT=0. Write addr 5 data 0x1A3 -> next cycle RAM_WE=1, RAM_WADDR=0x405, RAM_WDATA=0x1A3.
- WR_FRAME_END, then DRV_FRAME_SYNC 100 cycles later:
  - WR_READY=0 and SWAP_PENDING=1 for those cycles.
  - RD_BANK=1 two edges after sync; FRAME_CNT=1.
  - Next write address = 0x005 (bank 0).
- WR_VALID with WR_FRAME_END in the same cycle -> that pixel is written to the back bank; the following WR_VALID is held (WR_READY=0) until the swap completes.
- DRV_FRAME_SYNC pulses with no WR_FRAME_END -> RD_BANK and FRAME_CNT unchanged. WR_FRAME_END coincident with sync -> no swap until the next sync.
- Assert RESET_N low while in ST_PEND -> all outputs return to reset values immediately; a later sync causes no swap.
- With HUB75_FB_SWAP_TIMEOUT_EN and SWAP_TIMEOUT=16: WR_FRAME_END, no sync -> swap after 16 cycles in ST_PEND, SWAP_ERR=1 and stays 1; without the macro, still pending after 1000 cycles.
